bcd2bin: RTL

BCD2BIN -- requirements
Module: bcd2bin

---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_sub3.sv | 12 +
 rtl/bcd2bin.sv | 117 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Digit thresholds and the result-width function live here so the top and digit cells agree.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int NDIG_MIN = 1;
    localparam int NDIG_MAX = 4;

    localparam logic [3:0] DIG_MAX = 4'd9;
    localparam logic [3:0] DIG_TH  = 4'd8;
    localparam logic [3:0] DIG_SUB = 4'd3;

    // Bits needed to hold 10^ndig - 1.
    function automatic int bw_of(input int ndig);
        case (ndig)
            1:       return 4;
            2:       return 7;
            3:       return 10;
            default: return 14;
        endcase
    endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Per-digit correction cell for reverse double-dabble.
// A digit that picked up a carried-in 8 during the right shift should only have gained 5.
module bcd_sub3
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= DIG_TH) ? (din - DIG_SUB) : din;

endmodule

// File: rtl/bcd2bin.sv
// Sequential packed-BCD to binary converter, one bit of result per clock.
// Optional LSB-first serial result stream enabled by defining BCD2BIN_SERIAL_EN.
//
// state | meaning
// IDLE  | waiting for start; loads W on start
// SHIFT | shifting W right, or reporting an invalid digit on the first cycle
module bcd2bin
    import bcd_pkg::*;
#(
    parameter  int NDIG = 2,
    localparam int BW   = bw_of(NDIG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4*NDIG-1:0] bcd,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [BW-1:0]   bin
`ifdef BCD2BIN_SERIAL_EN
   ,output logic            sout,
    output logic            svalid
`endif
);

    localparam int WW = 4*NDIG + BW;
    localparam int CW = $clog2(BW + 1);

    state_t          state;
    logic [WW-1:0]   w;
    logic [WW-1:0]   w_shr;
    logic [WW-1:0]   w_next;
    logic [CW-1:0]   cnt;
    logic            bad;
    logic            bcd_bad;

    assign w_shr = w >> 1;

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_dig
            bcd_sub3 u_sub3 (
                .din  (w_shr[BW + 4*g +: 4]),
                .dout (w_next[BW + 4*g +: 4])
            );
        end
    endgenerate

    assign w_next[BW-1:0] = w_shr[BW-1:0];

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] > DIG_MAX) bcd_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            w      <= '0;
            cnt    <= '0;
            bad    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            bin    <= '0;
`ifdef BCD2BIN_SERIAL_EN
            sout   <= 1'b0;
            svalid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef BCD2BIN_SERIAL_EN
            svalid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        w     <= {bcd, {BW{1'b0}}};
                        bad   <= bcd_bad;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bad) begin
                        // invalid digit: report straight away, bin keeps last good result
                        bad   <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        w   <= w_next;
                        cnt <= cnt + CW'(1);
`ifdef BCD2BIN_SERIAL_EN
                        sout   <= w[BW];
                        svalid <= 1'b1;
`endif
                        if (cnt == CW'(BW - 1)) begin
                            bin   <= w_next[BW-1:0];
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
